byte_decode: RTL and testbench
==============================

// Module: byte_decode
// PURPOSE
//  Streaming ByteDecode_d: inverse of the encode stage. Consumes a byte stream of one
//  packed polynomial (32*D bytes) and emits its 256 D-bit coefficients in order.
//  Sits between the byte-level key/ciphertext buffer and the NTT/decompress stages.
//  For D=12, each coefficient is reduced mod Q, and a sticky flag reports non-canonical
//  input (FIPS 203 modulus check).
// PARAMETERS
//  D        12    bits per coefficient, 1..12
//  Q        3329  modulus; reduction only when D==12
//  N_COEF   256   coefficients per polynomial
// PORTS
//  clk_i        in   1   clock, rising edge
//  rst_ni       in   1   reset; asynchronous, active-low
//  start_i      in   1   pulse: begin decoding one polynomial
//  in_data_i    in   8   packed byte, LSB-first bit order
//  in_valid_i   in   1   byte available
//  in_ready_o   out  1   byte accepted when in_valid_i && in_ready_o
//  out_data_o   out  12  coefficient, zero-extended above bit D-1
//  out_idx_o    out  8   index (0..255) of out_data_o
//  out_valid_o  out  1   coefficient available
//  out_ready_i  in   1   coefficient taken when out_valid_o && out_ready_i
//  busy_o       out  1   high in RUN and FLUSH
//  done_o       out  1   one-cycle pulse after the last coefficient handshake
//  mod_err_o    out  1   sticky: some raw 12-bit value was >= Q (D==12 only)
// BEHAVIOUR
//  Reset: state=IDLE. bit buffer, bit_cnt, coef_cnt, and all outputs are 0.
//  FSM:
//   IDLE  : start_i -> RUN. Clear buffer, bit_cnt, coef_cnt, and mod_err_o.
//   RUN   : after the 256th coefficient is loaded into the output register -> FLUSH.
//   FLUSH : on the final out handshake -> IDLE, with done_o=1 for exactly that next cycle.
//   start_i outside IDLE is ignored.
//  Bit buffer:
//   - (D+7) bits wide; bit_cnt ranges 0..D+7.
//   - in_ready_o = (state==RUN) && (bit_cnt < D). This is combinational from registered state only.
//   - Accepted byte is ORed in at bit position bit_cnt; then bit_cnt += 8.
//  Output register load:
//   - Condition: bit_cnt >= D and (!out_valid_o || out_ready_i) and state==RUN.
//   - Action: raw = buf[D-1:0]; buffer >>= D; bit_cnt -= D; coef_cnt++.
//   - Loaded values: out_idx_o = coef_cnt; out_valid_o = 1.
//   - Byte accept and load are mutually exclusive by construction (bit_cnt<D vs >=D).
//   - Throughput: one load per cycle. out_data_o and out_idx_o are held stable while out_valid_o && !out_ready_i.
//   - out_valid_o clears on handshake unless a new load happens in the same cycle.
//  Arithmetic:
//   - D==12: out = (raw >= Q) ? raw - Q : raw. One subtraction suffices since 4095 < 2Q.
//     mod_err_o is set in the cycle after any load where raw >= Q.
//   - D<12: out = raw, no reduction; mod_err_o stays 0.
//  Byte count:
//   - Exactly 32*D bytes are accepted per polynomial; the buffer is empty (bit_cnt=0) at FLUSH.
//   - No bytes are accepted in FLUSH or IDLE; the extra upstream bytes wait.
//  Coefficient ordering: coefficient i = bits [i*D +: D] of the LSB-first concatenated stream.
//  Reset mid-operation: async return to IDLE. Partial data is discarded, no done_o, mod_err_o cleared.
// TESTING
//  1. D=12: start, bytes 0x6A,0xD0,0x64; out_ready=1 -> coeffs 106 (idx0), 1613 (idx1); mod_err=0.
//  2. D=12: bytes 0xFF,0xFF,0xFF -> coeffs 766, 766; mod_err_o=1, stays set until next start.
//  3. D=12: full 384-byte poly from a known 256-coeff vector, random in_valid/out_ready ->
//     256 coeffs match in order; exactly one done_o pulse; in_ready_o=0 after byte 383.
//  4. D=1: byte 0xA5 -> coeffs 1,0,1,0,0,1,0,1 (idx 0..7); 32 bytes total -> done_o.
//  5. Backpressure D=12: hold out_ready=0 for 10 cycles -> out_data/out_idx stable, in_ready drops
//     once bit_cnt>=12, no byte or coefficient lost after release.
//  6. Assert rst_ni low after 100 bytes -> all outputs 0 immediately; a new start decodes from idx 0.

Source files
------------

// File: rtl/byte_decode.sv
// Streaming byte-to-coefficient unpacker. Accepts an LSB-first byte stream and
// emits N_COEF D-bit coefficients. When D is 12, each value is reduced mod Q.
module byte_decode #(
    parameter int D      = 12,
    parameter int Q      = 3329,
    parameter int N_COEF = 256
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [7:0]  in_data_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    output logic [11:0] out_data_o,
    output logic [7:0]  out_idx_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        mod_err_o
);

    // state   | meaning
    // S_IDLE  | waiting for start_i
    // S_RUN   | accepting bytes and loading coefficients
    // S_FLUSH | last coefficient loaded, waiting for its handshake
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    localparam int BW = D + 7;
    localparam int CW = $clog2(D + 8);
    localparam int NW = $clog2(N_COEF);

    localparam logic [CW-1:0] D_C    = CW'(D);
    localparam logic [CW-1:0] BYTE_C = CW'(8);
    localparam logic [11:0]   Q_C    = 12'(Q);
    localparam logic [NW-1:0] LAST_C = NW'(N_COEF - 1);

    logic [1:0]    state;
    logic [BW-1:0] bit_buf;
    logic [CW-1:0] bit_cnt;
    logic [NW-1:0] coef_cnt;
    logic [11:0]   out_data;
    logic [7:0]    out_idx;
    logic          out_valid;
    logic          done;
    logic          mod_err;

    logic          accept;
    logic          load;
    logic          out_hs;
    logic          last;
    logic          over;
    logic [11:0]   raw;
    logic [11:0]   reduced;
    logic [BW-1:0] byte_sh;

    assign in_ready_o  = (state == S_RUN) && (bit_cnt < D_C);
    assign busy_o      = (state != S_IDLE);
    assign out_data_o  = out_data;
    assign out_idx_o   = out_idx;
    assign out_valid_o = out_valid;
    assign done_o      = done;
    assign mod_err_o   = mod_err;

    assign accept  = in_valid_i && in_ready_o;
    assign out_hs  = out_valid && out_ready_i;
    assign load    = (state == S_RUN) && (bit_cnt >= D_C) && (!out_valid || out_ready_i);
    assign last    = (coef_cnt == LAST_C);
    assign raw     = 12'(bit_buf[D-1:0]);
    // 4095 < 2Q, so a single conditional subtraction is a full reduction
    assign over    = (D == 12) && (raw >= Q_C);
    assign reduced = over ? (raw - Q_C) : raw;
    assign byte_sh = BW'(in_data_i) << bit_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= S_IDLE;
            bit_buf   <= '0;
            bit_cnt   <= '0;
            coef_cnt  <= '0;
            out_data  <= '0;
            out_idx   <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            mod_err   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        state    <= S_RUN;
                        bit_buf  <= '0;
                        bit_cnt  <= '0;
                        coef_cnt <= '0;
                        mod_err  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (load && last) state <= S_FLUSH;
                end
                S_FLUSH: begin
                    if (out_hs) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // accept needs bit_cnt < D and load needs bit_cnt >= D, so at most one fires
            if (accept) begin
                bit_buf <= bit_buf | byte_sh;
                bit_cnt <= bit_cnt + BYTE_C;
            end else if (load) begin
                bit_buf   <= bit_buf >> D;
                bit_cnt   <= bit_cnt - D_C;
                coef_cnt  <= coef_cnt + 1'b1;
                out_data  <= reduced;
                out_idx   <= 8'(coef_cnt);
                out_valid <= 1'b1;
                if (over) mod_err <= 1'b1;
            end

            if (!load && out_hs) out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_byte_decode.sv
// Bench for byte_decode: a D=12 and a D=1 instance checked against a bit-level
// model of the packed stream, plus literal expectations for known vectors.
`timescale 1ns/1ps
module tb_byte_decode;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // D=12 instance signals
    logic        start12 = 1'b0, in_valid12 = 1'b0, out_ready12 = 1'b0;
    logic [7:0]  in_data12 = 8'h00;
    logic        in_ready12, ov12, busy12, done12, mod_err12;
    logic [11:0] od12;
    logic [7:0]  oi12;

    // D=1 instance signals
    logic        start1 = 1'b0, in_valid1 = 1'b0, out_ready1 = 1'b0;
    logic [7:0]  in_data1 = 8'h00;
    logic        in_ready1, ov1, busy1, done1, mod_err1;
    logic [11:0] od1;
    logic [7:0]  oi1;

    byte_decode #(.D(12), .Q(3329), .N_COEF(256)) dut12 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start12),
        .in_data_i(in_data12), .in_valid_i(in_valid12), .in_ready_o(in_ready12),
        .out_data_o(od12), .out_idx_o(oi12), .out_valid_o(ov12), .out_ready_i(out_ready12),
        .busy_o(busy12), .done_o(done12), .mod_err_o(mod_err12));

    byte_decode #(.D(1), .Q(3329), .N_COEF(256)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start1),
        .in_data_i(in_data1), .in_valid_i(in_valid1), .in_ready_o(in_ready1),
        .out_data_o(od1), .out_idx_o(oi1), .out_valid_o(ov1), .out_ready_i(out_ready1),
        .busy_o(busy1), .done_o(done1), .mod_err_o(mod_err1));

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // stream storage and tracking state
    logic [7:0] b12 [384];
    logic [7:0] b1  [32];
    int nbytes12 = 0;
    int ptr12 = 0, ncoef12 = 0, done_cnt12 = 0;
    int ptr1 = 0, ncoef1 = 0, done_cnt1 = 0;
    int got12 [8];
    int got1 [8];
    int vprob = 100, rprob = 100;
    bit act12 = 0, act1 = 0;
    bit hold12 = 0, last_hs12 = 0, last_hs1 = 0;
    int hd12 = 0, hi12 = 0;

    function automatic int raw12(input int i);
        int r = 0;
        for (int k = 0; k < 12; k++) begin
            int p = i * 12 + k;
            if (b12[p / 8][p % 8]) r = r | (1 << k);
        end
        return r;
    endfunction

    function automatic int exp12(input int i);
        int r = raw12(i);
        return (r >= 3329) ? r - 3329 : r;
    endfunction

    function automatic int exp_err12();
        for (int i = 0; i < 256; i++) if (raw12(i) >= 3329) return 1;
        return 0;
    endfunction

    function automatic int exp1(input int i);
        return int'(b1[i / 8][i % 8]);
    endfunction

    task automatic pack_vec12();
        for (int j = 0; j < 384; j++) b12[j] = 8'h00;
        for (int i = 0; i < 256; i++) begin
            int c = (i * 1103 + 77) % 4096;
            for (int k = 0; k < 12; k++) begin
                int p = i * 12 + k;
                if (((c >> k) & 1) == 1) b12[p / 8][p % 8] = 1'b1;
            end
        end
        nbytes12 = 384;
    endtask

    // drivers: inputs change 1ns after the rising edge
    always @(posedge clk) begin
        #1;
        in_valid12  = act12 && (ptr12 < nbytes12) && (int'($urandom_range(0, 99)) < vprob);
        in_data12   = (ptr12 < nbytes12) ? b12[ptr12] : 8'h00;
        out_ready12 = act12 && (int'($urandom_range(0, 99)) < rprob);
        in_valid1   = act1 && (ptr1 < 32);
        in_data1    = (ptr1 < 32) ? b1[ptr1] : 8'h00;
        out_ready1  = act1;
    end

    // compare process for the D=12 instance
    always @(negedge clk) begin
        if (rst_n) begin
            if (hold12) begin
                chk("hold_valid", int'(ov12), 1);
                chk("hold_data", int'(od12), hd12);
                chk("hold_idx", int'(oi12), hi12);
            end
            chk("done12", int'(done12), int'(last_hs12));
            if (done12) done_cnt12++;
            last_hs12 = 0;
            if (!busy12) chk("in_ready_idle", int'(in_ready12), 0);
            if (ptr12 >= 384) chk("in_ready_full", int'(in_ready12), 0);
            if (in_valid12 && in_ready12) ptr12++;
            if (ov12 && out_ready12) begin
                chk("idx12", int'(oi12), ncoef12);
                chk("data12", int'(od12), exp12(ncoef12));
                if (ncoef12 < 8) got12[ncoef12] = int'(od12);
                ncoef12++;
                if (ncoef12 == 256) last_hs12 = 1;
            end
            hold12 = ov12 && !out_ready12;
            hd12 = int'(od12);
            hi12 = int'(oi12);
        end
    end

    // compare process for the D=1 instance
    always @(negedge clk) begin
        if (rst_n) begin
            chk("done1", int'(done1), int'(last_hs1));
            if (done1) done_cnt1++;
            last_hs1 = 0;
            if (in_valid1 && in_ready1) ptr1++;
            if (ov1 && out_ready1) begin
                chk("idx1", int'(oi1), ncoef1 % 256);
                chk("data1", int'(od1), exp1(ncoef1));
                if (ncoef1 < 8) got1[ncoef1] = int'(od1);
                ncoef1++;
                if (ncoef1 == 256) last_hs1 = 1;
            end
        end
    end

    task automatic reset_dut();
        rst_n = 1'b0;
        act12 = 0; act1 = 0;
        start12 = 1'b0; start1 = 1'b0;
        ptr12 = 0; ncoef12 = 0; done_cnt12 = 0; hold12 = 0; last_hs12 = 0;
        ptr1 = 0; ncoef1 = 0; done_cnt1 = 0; last_hs1 = 0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic start_12();
        @(posedge clk); #1 start12 = 1'b1;
        @(posedge clk); #1 start12 = 1'b0;
    endtask

    task automatic wait_done12(input int budget);
        int c = 0;
        while (done_cnt12 == 0 && c < budget) begin
            @(posedge clk);
            c++;
        end
        chk("timeout_done12", int'(c < budget), 1);
        repeat (3) @(posedge clk);
    endtask

    task automatic wait_coefs12(input int n, input int budget);
        int c = 0;
        while (ncoef12 < n && c < budget) begin
            @(posedge clk);
            c++;
        end
        chk("timeout_coefs12", int'(c < budget), 1);
    endtask

    task automatic check_all_zero12(input string tag);
        chk({tag, "_ov"}, int'(ov12), 0);
        chk({tag, "_od"}, int'(od12), 0);
        chk({tag, "_oi"}, int'(oi12), 0);
        chk({tag, "_in_ready"}, int'(in_ready12), 0);
        chk({tag, "_busy"}, int'(busy12), 0);
        chk({tag, "_done"}, int'(done12), 0);
        chk({tag, "_mod_err"}, int'(mod_err12), 0);
    endtask

    initial begin
        int c;
        reset_dut();
        #1;
        check_all_zero12("reset12");
        chk("reset1_ov", int'(ov1), 0);
        chk("reset1_busy", int'(busy1), 0);
        chk("reset1_in_ready", int'(in_ready1), 0);

        // D=1: 0xA5 first, then 31 more bytes
        b1[0] = 8'hA5;
        for (int j = 1; j < 32; j++) b1[j] = 8'(8'h3C ^ j[7:0]);
        act1 = 1;
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        c = 0;
        while (done_cnt1 == 0 && c < 2000) begin @(posedge clk); c++; end
        chk("timeout_done1", int'(c < 2000), 1);
        repeat (3) @(posedge clk);
        chk("d1_c0", got1[0], 1); chk("d1_c1", got1[1], 0);
        chk("d1_c2", got1[2], 1); chk("d1_c3", got1[3], 0);
        chk("d1_c4", got1[4], 0); chk("d1_c5", got1[5], 1);
        chk("d1_c6", got1[6], 0); chk("d1_c7", got1[7], 1);
        chk("d1_bytes", ptr1, 32);
        chk("d1_ncoef", ncoef1, 256);
        chk("d1_done_cnt", done_cnt1, 1);
        chk("d1_mod_err", int'(mod_err1), 0);

        // D=12 short vector: 106, 1613
        reset_dut();
        b12[0] = 8'h6A; b12[1] = 8'hD0; b12[2] = 8'h64; nbytes12 = 3;
        vprob = 100; rprob = 100; act12 = 1;
        start_12();
        wait_coefs12(2, 200);
        repeat (3) @(posedge clk);
        chk("t1_c0", got12[0], 106);
        chk("t1_c1", got12[1], 1613);
        chk("t1_mod_err", int'(mod_err12), 0);

        // D=12 all-ones polynomial: every coefficient 766, sticky error
        reset_dut();
        for (int j = 0; j < 384; j++) b12[j] = 8'hFF;
        nbytes12 = 384;
        act12 = 1;
        start_12();
        wait_done12(3000);
        chk("t2_c0", got12[0], 766);
        chk("t2_c1", got12[1], 766);
        chk("t2_ncoef", ncoef12, 256);
        chk("t2_bytes", ptr12, 384);
        chk("t2_done_cnt", done_cnt12, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("t2_mod_err_sticky", int'(mod_err12), 1);
        chk("t2_busy", int'(busy12), 0);

        // D=12 full polynomial with random flow control
        pack_vec12();
        ptr12 = 0; ncoef12 = 0; done_cnt12 = 0;
        vprob = 70; rprob = 70;
        start_12();
        chk("t3_mod_err_cleared", int'(mod_err12), 0);
        chk("t3_busy", int'(busy12), 1);
        wait_done12(5000);
        chk("t3_ncoef", ncoef12, 256);
        chk("t3_bytes", ptr12, 384);
        chk("t3_done_cnt", done_cnt12, 1);
        chk("t3_mod_err", int'(mod_err12), exp_err12());
        chk("t3_c0", got12[0], 77);
        chk("t3_c1", got12[1], 1180);

        // backpressure: out_ready held low
        ptr12 = 0; ncoef12 = 0; done_cnt12 = 0;
        vprob = 100; rprob = 0;
        start_12();
        repeat (10) @(posedge clk);
        #2;
        chk("t5_in_ready", int'(in_ready12), 0);
        chk("t5_ov", int'(ov12), 1);
        chk("t5_idx", int'(oi12), 0);
        chk("t5_data", int'(od12), 77);
        chk("t5_bytes", ptr12, 3);
        rprob = 100;
        wait_done12(3000);
        chk("t5_ncoef", ncoef12, 256);
        chk("t5_done_cnt", done_cnt12, 1);

        // reset mid-polynomial
        ptr12 = 0; ncoef12 = 0; done_cnt12 = 0;
        vprob = 80; rprob = 80;
        start_12();
        c = 0;
        while (ptr12 < 100 && c < 1000) begin @(posedge clk); c++; end
        chk("timeout_t6_bytes", int'(c < 1000), 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero12("t6");
        reset_dut();
        act12 = 1; vprob = 90; rprob = 90;
        start_12();
        wait_done12(4000);
        chk("t6_ncoef", ncoef12, 256);
        chk("t6_done_cnt", done_cnt12, 1);
        chk("t6_c0", got12[0], 77);

        act12 = 0;
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
